// File: rtl/mux8_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux8_rr_arbiter
//
// Purpose:
//   Round-robin arbiter and sequencer for an 8:1 data mux. Eight requesters
//   share a single output channel. The block picks an owner, drives a
//   registered 3-bit select and one-hot grant, and forwards the owner's data
//   under a valid/ready handshake. An owner keeps the channel for at most
//   MAX_HOLD accepted beats. After that, or when it drops its request, the
//   channel is re-arbitrated in the same cycle, so no bubble is inserted.
//
// Parameters:
//   DATA_W    width of each requester data word and of out_data
//   MAX_HOLD  maximum accepted beats per grant before forced rotation (>=1)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req[7:0]   per-channel request level, held while that channel has data
//   in_data    channel k data at [k*DATA_W +: DATA_W]
//   out_valid  output beat valid (owner still requesting)
//   out_ready  downstream accepts a beat when out_valid & out_ready
//   out_data   data of the granted channel, zero when out_valid is low
//   sel[2:0]   registered select of the current owner
//   grant[7:0] registered one-hot owner, zero while idle
//   busy       high while a grant is active
//
// Build option:
//   MUX8_ARB_PRIO0_EN  when defined, channel 0 has strict priority at every
//                      arbitration point. A grant to channel 0 leaves the
//                      rotation pointer untouched, so rotation among channels
//                      1..7 is preserved. When channel 0 gives up the channel
//                      after its own grant, it yields once to any other
//                      requester, so MAX_HOLD still forces rotation away from
//                      it. It is re-granted only when it is the sole requester.
//                      When undefined, all 8 channels are arbitrated by pure
//                      round-robin.
// -----------------------------------------------------------------------------
module mux8_rr_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          req,
  input  logic [8*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [2:0]          sel,
  output logic [7:0]          grant,
  output logic                busy
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Round-robin search starting just after ptr. The result is {found, index}.
  // The search wraps, so ptr itself is the last candidate. This lets a lone
  // requester be re-granted.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic       found;
    logic [2:0] win;
    logic [2:0] idx;
    found = 1'b0;
    win   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

  // Convert a channel index into its one-hot grant vector.
  function automatic logic [7:0] to_onehot(input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'h01 << idx;
    return oh;
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [2:0]       sel_r;
  logic [2:0]       sel_next_s;
  logic [7:0]       grant_r;
  logic [7:0]       grant_next_s;
  logic [2:0]       ptr_r;
  logic [2:0]       ptr_next_s;
  logic [CNT_W-1:0] beat_cnt_r;
  logic [CNT_W-1:0] beat_cnt_next_s;
  logic             busy_r;

  logic             out_valid_s;
  logic [DATA_W-1:0] out_data_s;
  logic             transfer_s;
  logic             release_s;

  logic [3:0]       rr_res_s;
  logic             pick_found_s;
  logic [2:0]       pick_idx_s;
  logic             pick_upd_ptr_s;
`ifdef MUX8_ARB_PRIO0_EN
  logic             ch0_yield_s;
`endif

  // Output handshake: the owner's request drives valid. Valid is blocked
  // during reset so that no beat is accepted in the reset cycle.
  always_comb begin
    out_valid_s = 1'b0;
    out_data_s  = {DATA_W{1'b0}};
    if (!rst && (state_r == ST_GRANT)) begin
      out_valid_s = req[sel_r];
    end else begin
      out_valid_s = 1'b0;
    end
    if (out_valid_s) begin
      out_data_s = in_data[sel_r*DATA_W +: DATA_W];
    end else begin
      out_data_s = {DATA_W{1'b0}};
    end
  end

  // Beat acceptance and the release condition of the current owner.
  always_comb begin
    transfer_s = out_valid_s & out_ready;
    release_s  = 1'b0;
    if (state_r == ST_GRANT) begin
      release_s = (transfer_s && (beat_cnt_r == HOLD_LAST)) || !req[sel_r];
    end else begin
      release_s = 1'b0;
    end
  end

  // Arbitration: pick the next owner from the request vector and the pointer.
  always_comb begin
    pick_found_s   = 1'b0;
    pick_idx_s     = 3'd0;
    pick_upd_ptr_s = 1'b0;
    rr_res_s       = 4'h0;
`ifdef MUX8_ARB_PRIO0_EN
    // Channel 0 yields once after its own grant, so its hold limit rotates it out.
    ch0_yield_s = (state_r == ST_GRANT) && (sel_r == 3'd0);
    rr_res_s    = rr_pick(req & 8'hFE, ptr_r);
    if (req[0] && !ch0_yield_s) begin
      pick_found_s   = 1'b1;
      pick_idx_s     = 3'd0;
      pick_upd_ptr_s = 1'b0;
    end else if (rr_res_s[3]) begin
      pick_found_s   = 1'b1;
      pick_idx_s     = rr_res_s[2:0];
      pick_upd_ptr_s = 1'b1;
    end else if (req[0]) begin
      pick_found_s   = 1'b1;
      pick_idx_s     = 3'd0;
      pick_upd_ptr_s = 1'b0;
    end else begin
      pick_found_s   = 1'b0;
      pick_idx_s     = 3'd0;
      pick_upd_ptr_s = 1'b0;
    end
`else
    // In pure round-robin mode, ptr always equals the last owner.
    rr_res_s       = rr_pick(req, ptr_r);
    pick_found_s   = rr_res_s[3];
    pick_idx_s     = rr_res_s[2:0];
    pick_upd_ptr_s = 1'b1;
`endif
  end

  // Next-state logic for the IDLE/GRANT sequencer.
  always_comb begin
    state_next_s    = state_r;
    sel_next_s      = sel_r;
    grant_next_s    = grant_r;
    ptr_next_s      = ptr_r;
    beat_cnt_next_s = beat_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_next_s    = ST_GRANT;
          sel_next_s      = pick_idx_s;
          grant_next_s    = to_onehot(pick_idx_s);
          ptr_next_s      = pick_upd_ptr_s ? pick_idx_s : ptr_r;
          beat_cnt_next_s = {CNT_W{1'b0}};
        end else begin
          state_next_s = ST_IDLE;
          grant_next_s = 8'h00;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          // Re-arbitrate in the release cycle so that the handover has no bubble.
          if (pick_found_s) begin
            state_next_s    = ST_GRANT;
            sel_next_s      = pick_idx_s;
            grant_next_s    = to_onehot(pick_idx_s);
            ptr_next_s      = pick_upd_ptr_s ? pick_idx_s : ptr_r;
            beat_cnt_next_s = {CNT_W{1'b0}};
          end else begin
            state_next_s    = ST_IDLE;
            grant_next_s    = 8'h00;
            beat_cnt_next_s = {CNT_W{1'b0}};
          end
        end else if (transfer_s) begin
          beat_cnt_next_s = beat_cnt_r + CNT_W'(1);
        end else begin
          beat_cnt_next_s = beat_cnt_r;
        end
      end
      default: begin
        state_next_s    = ST_IDLE;
        grant_next_s    = 8'h00;
        beat_cnt_next_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, ownership and pointer registers. Reset aborts any active grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      sel_r      <= 3'd0;
      grant_r    <= 8'h00;
      ptr_r      <= 3'd7;
      beat_cnt_r <= {CNT_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      sel_r      <= sel_next_s;
      grant_r    <= grant_next_s;
      ptr_r      <= ptr_next_s;
      beat_cnt_r <= beat_cnt_next_s;
      busy_r     <= (state_next_s == ST_GRANT);
    end
  end

  assign out_valid = out_valid_s;
  assign out_data  = out_data_s;
  assign sel       = sel_r;
  assign grant     = grant_r;
  assign busy      = busy_r;

endmodule
